// File: rtl/power_spectrum_pkg.sv
// Shared constants and types for the power-spectrum block: default bin
// count, frame index/number widths and the sequencer state encoding.
package power_spectrum_pkg;

  localparam int N_BIN = 513;  // bins per frame, indices 0..N_BIN-1
  localparam int IDX_W = 10;   // width of the bin index within a frame
  localparam int NUM_W = 7;    // width of the frame number

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ps_square_sum.sv
// Square/sum/saturate datapath. Stage 2 squares the registered real and
// imaginary parts at full width. Stage 3 adds the squares and clamps the
// sum to the output width.
module ps_square_sum #(
  parameter int I_BW = 14,
  parameter int O_BW = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic signed [I_BW-1:0] in_re,
  input  logic signed [I_BW-1:0] in_im,
  output logic                   out_en,
  output logic [O_BW-1:0]        out_pow
);

  localparam int SQ_W  = 2 * I_BW;
  localparam int SUM_W = SQ_W + 1;

  logic signed [SQ_W-1:0] re_ext;
  logic signed [SQ_W-1:0] im_ext;
  logic [SQ_W-1:0]        sq_re;
  logic [SQ_W-1:0]        sq_im;
  logic                   sq_en;
  logic [SUM_W-1:0]       sum;
  logic [O_BW-1:0]        pow_sat;

  // Sign-extend the operands so each product is formed at full width.
  always_comb begin
    re_ext = SQ_W'(in_re);
    im_ext = SQ_W'(in_im);
    sum    = {1'b0, sq_re} + {1'b0, sq_im};
  end

  // Clamp the sum to the output range; no clamp is needed when the output is wide enough.
  if (O_BW >= SUM_W) begin : g_wide
    assign pow_sat = O_BW'(sum);
  end else begin : g_sat
    always_comb begin
      pow_sat = (|sum[SUM_W-1:O_BW]) ? {O_BW{1'b1}} : sum[O_BW-1:0];
    end
  end

  // Stage 2 valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_en <= 1'b0;
    end else begin
      sq_en <= in_en;
    end
  end

  // Stage 2 squares. A square is never negative, so it is stored unsigned.
  always_ff @(posedge clk) begin
    sq_re <= re_ext * re_ext;
    sq_im <= im_ext * im_ext;
  end

  // Stage 3 output register. The power holds its last value between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en  <= 1'b0;
      out_pow <= '0;
    end else begin
      out_en <= sq_en;
      if (sq_en) begin
        out_pow <= pow_sat;
      end
    end
  end

endmodule

// File: rtl/power_spectrum.sv
// Power spectrum per FFT bin: do_pow = re^2 + im^2, with a 3-cycle latency.
// A sequencer admits only in-order bins of a frame. It drops or restarts on
// sequencing violations and flags the last bin of each completed frame.
module power_spectrum #(
  parameter int I_BW  = 14,
  parameter int O_BW  = 28,
  parameter int N_BIN = power_spectrum_pkg::N_BIN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                di_en,
  input  logic signed [I_BW-1:0]              di_re,
  input  logic signed [I_BW-1:0]              di_im,
  input  logic [power_spectrum_pkg::IDX_W-1:0] in_group_idx,
  input  logic [power_spectrum_pkg::NUM_W-1:0] in_group_num,
  output logic                                do_en,
  output logic [O_BW-1:0]                     do_pow,
  output logic [power_spectrum_pkg::IDX_W-1:0] out_group_idx,
  output logic [power_spectrum_pkg::NUM_W-1:0] out_group_num,
  output logic                                frame_done,
  output logic                                err_seq
);

  import power_spectrum_pkg::*;

  localparam logic [IDX_W:0]   N_BIN_C  = (IDX_W + 1)'(N_BIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BIN - 1);

  seq_state_t             state, state_nx;
  logic [IDX_W-1:0]       exp_idx, exp_idx_nx;
  logic [NUM_W-1:0]       cur_num, cur_num_nx;
  logic                   accept;
  logic                   seq_err;
  logic                   in_range;
  logic                   is_last;

  logic                   s1_en, s1_last;
  logic signed [I_BW-1:0] s1_re, s1_im;
  logic [IDX_W-1:0]       s1_idx;
  logic [NUM_W-1:0]       s1_num;
  logic                   s2_en, s2_last;
  logic [IDX_W-1:0]       s2_idx;
  logic [NUM_W-1:0]       s2_num;

  // Sequencer decision: accept, drop or restart the incoming sample.
  always_comb begin
    // NOTE: each output gets a default first, so no path can infer a latch.
    state_nx   = state;
    exp_idx_nx = exp_idx;
    cur_num_nx = cur_num;
    accept     = 1'b0;
    seq_err    = 1'b0;
    in_range   = ({1'b0, in_group_idx} < N_BIN_C);
    is_last    = (in_group_idx == LAST_IDX);
    if (di_en && in_range) begin
      case (state)
        ST_IDLE: begin
          if (in_group_idx == '0) begin
            accept     = 1'b1;
            cur_num_nx = in_group_num;
            exp_idx_nx = IDX_W'(1);
            state_nx   = ST_RUN;
          end else begin
            seq_err = 1'b1;
          end
        end
        ST_RUN: begin
          if (in_group_idx == exp_idx && in_group_num == cur_num) begin
            accept     = 1'b1;
            exp_idx_nx = exp_idx + IDX_W'(1);
          end else if (in_group_idx == '0) begin
            // An index 0 out of order starts a new frame and keeps the sample.
            seq_err    = 1'b1;
            accept     = 1'b1;
            cur_num_nx = in_group_num;
            exp_idx_nx = IDX_W'(1);
          end else begin
            seq_err    = 1'b1;
            state_nx   = ST_IDLE;
            exp_idx_nx = '0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
      if (accept && is_last) begin
        state_nx   = ST_IDLE;
        exp_idx_nx = '0;
      end
    end
  end

  // Sequencer state, expected index, latched frame number and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= ST_IDLE;
      exp_idx <= '0;
      cur_num <= '0;
      err_seq <= 1'b0;
    end else begin
      state   <= state_nx;
      exp_idx <= exp_idx_nx;
      cur_num <= cur_num_nx;
      err_seq <= seq_err;
    end
  end

  // Stage 1 and stage 2 valid flags. The last-bin marker is already qualified by accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_en   <= 1'b0;
      s1_last <= 1'b0;
      s2_en   <= 1'b0;
      s2_last <= 1'b0;
    end else begin
      s1_en   <= accept;
      s1_last <= accept & is_last;
      s2_en   <= s1_en;
      s2_last <= s1_en & s1_last;
    end
  end

  // Stage 1 and stage 2 payload registers, aligned with the valid flags.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; the valid flags alone decide what reaches the outputs.
    s1_re  <= di_re;
    s1_im  <= di_im;
    s1_idx <= in_group_idx;
    s1_num <= in_group_num;
    s2_idx <= s1_idx;
    s2_num <= s1_num;
  end

  // Stage 3 tag outputs. These are aligned with do_pow from the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_group_idx <= '0;
      out_group_num <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= s2_en & s2_last;
      if (s2_en) begin
        out_group_idx <= s2_idx;
        out_group_num <= s2_num;
      end
    end
  end

  ps_square_sum #(
    .I_BW (I_BW),
    .O_BW (O_BW)
  ) u_square_sum (
    .clk     (clk),
    .rst     (rst),
    .in_en   (s1_en),
    .in_re   (s1_re),
    .in_im   (s1_im),
    .out_en  (do_en),
    .out_pow (do_pow)
  );

endmodule

// File: tb/tb_power_spectrum.sv
// Self-checking bench for power_spectrum. Two instances share the stimulus:
// one uses the default 28-bit output and one uses a 27-bit output that
// saturates. A frame-level reference model schedules the expected outputs
// by cycle number.
module tb_power_spectrum;

  localparam int     I_BW  = 14;
  localparam int     N_BIN = 513;
  localparam longint MAX28 = (64'sd1 <<< 28) - 1;
  localparam longint MAX27 = (64'sd1 <<< 27) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   di_en;
  logic signed [I_BW-1:0] di_re, di_im;
  logic [9:0]             in_group_idx;
  logic [6:0]             in_group_num;

  logic        a_do_en, a_frame_done, a_err_seq;
  logic [27:0] a_do_pow;
  logic [9:0]  a_out_group_idx;
  logic [6:0]  a_out_group_num;
  logic        b_do_en, b_frame_done, b_err_seq;
  logic [26:0] b_do_pow;
  logic [9:0]  b_out_group_idx;
  logic [6:0]  b_out_group_num;

  power_spectrum #(.I_BW(I_BW), .O_BW(28), .N_BIN(N_BIN)) dut (
    .clk(clk), .rst(rst), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .in_group_idx(in_group_idx), .in_group_num(in_group_num),
    .do_en(a_do_en), .do_pow(a_do_pow), .out_group_idx(a_out_group_idx),
    .out_group_num(a_out_group_num), .frame_done(a_frame_done), .err_seq(a_err_seq)
  );

  power_spectrum #(.I_BW(I_BW), .O_BW(27), .N_BIN(N_BIN)) dut_sat (
    .clk(clk), .rst(rst), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .in_group_idx(in_group_idx), .in_group_num(in_group_num),
    .do_en(b_do_en), .do_pow(b_do_pow), .out_group_idx(b_out_group_idx),
    .out_group_num(b_out_group_num), .frame_done(b_frame_done), .err_seq(b_err_seq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int en_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (a_do_en) en_cnt++;
    if (a_frame_done) done_cnt++;
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit     en;
    longint p28;
    longint p27;
    int     idx;
    int     num;
    bit     done;
  } exp_t;

  typedef struct {
    int     re;
    int     im;
    longint exp28;
    longint exp27;
  } vec_t;

  exp_t exp_out[int];
  bit   exp_err[int];

  // Reference sequencer, tracked at the frame level.
  bit m_in_frame = 1'b0;
  int m_next = 0;
  int m_num = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare both instances against the expectations scheduled for this cycle.
  task automatic compare_now();
    exp_t        e;
    bit          ee;
    logic [47:0] act_a, exp_a, act_b, exp_b;
    e = '{default: 0};
    if (exp_out.exists(cyc)) begin
      e = exp_out[cyc];
      exp_out.delete(cyc);
    end
    ee = exp_err.exists(cyc);
    if (ee) exp_err.delete(cyc);
    act_a = {a_do_en, a_frame_done, a_err_seq, 45'd0};
    exp_a = {e.en, e.done, ee, 45'd0};
    act_b = {b_do_en, b_frame_done, b_err_seq, 45'd0};
    exp_b = exp_a;
    if (e.en) begin
      act_a[44:0] = {a_do_pow, a_out_group_idx, a_out_group_num};
      exp_a[44:0] = {28'(e.p28), 10'(e.idx), 7'(e.num)};
      act_b[44:0] = {1'b0, b_do_pow, b_out_group_idx, b_out_group_num};
      exp_b[44:0] = {28'(e.p27), 10'(e.idx), 7'(e.num)};
    end
    check("out_o28", act_a, exp_a);
    check("out_o27", act_b, exp_b);
  endtask

  // One clock cycle: check the outputs, drive the inputs and schedule the model response.
  task automatic drive_cycle(input bit r, input bit en, input int re, input int im,
                             input int idx, input int num, input longint p28, input longint p27);
    bit accept, err, done;
    int ks[$];
    @(negedge clk);
    compare_now();
    rst          = r;
    di_en        = en;
    di_re        = I_BW'(re);
    di_im        = I_BW'(im);
    in_group_idx = 10'(idx);
    in_group_num = 7'(num);
    accept = 1'b0;
    err    = 1'b0;
    done   = 1'b0;
    if (r) begin
      foreach (exp_out[k]) if (k > cyc) ks.push_back(k);
      foreach (ks[i]) exp_out.delete(ks[i]);
      ks.delete();
      foreach (exp_err[k]) if (k > cyc) ks.push_back(k);
      foreach (ks[i]) exp_err.delete(ks[i]);
      m_in_frame = 1'b0;
      m_next     = 0;
      m_num      = 0;
    end else if (en && idx < N_BIN) begin
      if (!m_in_frame) begin
        if (idx == 0) begin
          accept = 1'b1; m_in_frame = 1'b1; m_num = num; m_next = 1;
        end else begin
          err = 1'b1;
        end
      end else if (idx == m_next && num == m_num) begin
        accept = 1'b1; m_next++;
      end else if (idx == 0) begin
        err = 1'b1; accept = 1'b1; m_num = num; m_next = 1;
      end else begin
        err = 1'b1; m_in_frame = 1'b0;
      end
      if (accept && idx == N_BIN - 1) begin
        done = 1'b1; m_in_frame = 1'b0;
      end
      if (err) exp_err[cyc + 1] = 1'b1;
      if (accept) exp_out[cyc + 3] = '{en: 1'b1, p28: p28, p27: p27, idx: idx, num: num, done: done};
    end
  endtask

  task automatic step(input bit en, input int re, input int im, input int idx, input int num);
    longint p;
    p = longint'(re) * re + longint'(im) * im;
    drive_cycle(1'b0, en, re, im, idx, num, (p > MAX28) ? MAX28 : p, (p > MAX27) ? MAX27 : p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  function automatic logic [47:0] raw_a();
    return {a_do_en, a_frame_done, a_err_seq, a_do_pow, a_out_group_idx, a_out_group_num};
  endfunction

  vec_t tbl[9];
  int   en0, dn0;

  initial begin
    rst = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0; in_group_idx = '0; in_group_num = '0;

    tbl[0] = '{3, -4, 25, 25};
    tbl[1] = '{0, 0, 0, 0};
    tbl[2] = '{-8192, -8192, 134217728, 134217727};
    tbl[3] = '{8191, 8191, 134184962, 134184962};
    tbl[4] = '{-8192, 0, 67108864, 67108864};
    tbl[5] = '{8191, -8192, 134201345, 134201345};
    tbl[6] = '{1, -1, 2, 2};
    tbl[7] = '{-1, -1, 2, 2};
    tbl[8] = '{100, -200, 50000, 50000};

    // Reset state.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    check("reset_state", raw_a(), 48'd0);
    idle(2);

    // Table vectors as bins 0..8 of frame 9, then finish that frame with random data.
    for (int i = 0; i < 9; i++)
      drive_cycle(1'b0, 1'b1, tbl[i].re, tbl[i].im, i, 9, tbl[i].exp28, tbl[i].exp27);
    for (int i = 9; i < N_BIN; i++) step(1'b1, rnd_s(), rnd_s(), i, 9);
    idle(5);

    // Frame 5, contiguous, constant 3-4j.
    en0 = en_cnt; dn0 = done_cnt;
    for (int i = 0; i < N_BIN; i++) step(1'b1, 3, -4, i, 5);
    idle(5);
    check("frame5_do_en_count", 48'(en_cnt - en0), 48'(N_BIN));
    check("frame5_done_count", 48'(done_cnt - dn0), 48'd1);

    // Restart at idx 0 after bin 511; only the second frame completes.
    dn0 = done_cnt;
    for (int i = 0; i < N_BIN - 1; i++) step(1'b1, rnd_s(), rnd_s(), i, 2);
    for (int i = 0; i < N_BIN; i++) step(1'b1, rnd_s(), rnd_s(), i, 3);
    idle(5);
    check("restart_done_count", 48'(done_cnt - dn0), 48'd1);

    // Out-of-range indices interleaved in a frame are ignored.
    dn0 = done_cnt;
    for (int i = 0; i < N_BIN; i++) begin
      step(1'b1, rnd_s(), rnd_s(), i, 7);
      if (i % 3 == 0) step(1'b1, rnd_s(), rnd_s(), int'($urandom_range(600, 1023)), 7);
    end
    idle(5);
    check("oor_done_count", 48'(done_cnt - dn0), 48'd1);

    // Stray index in IDLE, then reset in the middle of a frame.
    idle(2);
    step(1'b1, 5, 5, 7, 0);
    idle(3);
    for (int i = 0; i <= 200; i++) step(1'b1, rnd_s(), rnd_s(), i, 1);
    drive_cycle(1'b1, 1'b1, 9, 9, 201, 1, 0, 0);
    drive_cycle(1'b1, 1'b1, 9, 9, 202, 1, 0, 0);
    check("midframe_reset_outputs", raw_a(), 48'd0);
    idle(4);
    step(1'b1, 1, 1, 201, 1);
    idle(4);

    // Randomized traffic with gaps, out-of-range bins and rare sequencing errors.
    for (int c = 0; c < 5000; c++) begin
      int r, idx, num;
      bit en;
      en = ($urandom_range(0, 9) != 0);
      r  = int'($urandom_range(0, 999));
      if (!m_in_frame) begin
        idx = (r < 900) ? 0 : int'($urandom_range(0, 1023));
        num = int'($urandom_range(0, 88));
      end else begin
        num = m_num;
        if (r < 50) idx = int'($urandom_range(513, 1023));
        else if (r < 997) idx = m_next;
        else if (r == 997) begin idx = 0; num = int'($urandom_range(0, 88)); end
        else if (r == 998) idx = int'($urandom_range(0, 512));
        else begin idx = m_next; num = (m_num + 1) % 89; end
      end
      step(en, rnd_s(), rnd_s(), idx, num);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/power_spectrum.md
POWER_SPECTRUM -- requirements
Module: power_spectrum

Interface
REQ-001 The block SHALL have parameter I_BW, default 14, signed width of input real/imag samples.
REQ-002 The block SHALL have parameter O_BW, default 28, unsigned width of output power.
REQ-003 The block SHALL have parameter N_BIN, default 513, number of bins per frame (indices 0..N_BIN-1).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port di_en  input  1  input sample valid.
REQ-007 The block SHALL have ports di_re, di_im  input  I_BW signed  FFT bin real/imag part.
REQ-008 The block SHALL have port in_group_idx  input  10  bin index within frame.
REQ-009 The block SHALL have port in_group_num  input  7  frame number (0-88).
REQ-010 The block SHALL have port do_en  output  1  output power valid.
REQ-011 The block SHALL have port do_pow  output  O_BW unsigned  re^2+im^2 of the bin.
REQ-012 The block SHALL have ports out_group_idx  output  10 and out_group_num  output  7, aligned with do_pow.
REQ-013 The block SHALL have port frame_done  output  1  one-cycle pulse with the last bin of a frame.
REQ-014 The block SHALL have port err_seq  output  1  one-cycle pulse on a sequencing violation.

Function
REQ-015 Accepted samples SHALL appear on do_pow exactly 3 cycles after di_en: stage 1 registers inputs, stage 2 squares, stage 3 sums and saturates.
REQ-016 Pipeline SHALL accept one sample per cycle with no stall, with idx/num/valid carried alongside data.
REQ-017 Squares SHALL be computed at full 2*I_BW width; the sum SHALL be 2*I_BW+1 bits wide before output.
REQ-018 If the sum exceeds 2^O_BW-1, do_pow SHALL saturate to 2^O_BW-1; otherwise it SHALL be exact.
REQ-019 Sequencer FSM SHALL have states IDLE and RUN, plus expected-index counter exp_idx and latched frame number cur_num.
REQ-020 In IDLE, sample with idx 0 SHALL be accepted, latch cur_num, set exp_idx=1, and go to RUN.
REQ-021 In IDLE, sample with idx != 0 and idx < N_BIN SHALL be dropped (no do_en) and SHALL raise err_seq.
REQ-022 Any sample with idx >= N_BIN SHALL be dropped silently, with no err_seq and no state change.
REQ-023 In RUN, sample with idx == exp_idx and num == cur_num SHALL be accepted and increment exp_idx.
REQ-024 In RUN, the accepted sample with idx == N_BIN-1 SHALL return FSM to IDLE and SHALL mark frame_done on its output cycle.
REQ-025 In RUN, a mismatch with idx 0 SHALL raise err_seq, restart the frame (latch new num, exp_idx=1), and accept the sample.
REQ-026 In RUN, any other mismatch (idx or num) SHALL raise err_seq, drop the sample, and go to IDLE.
REQ-027 err_seq SHALL pulse 1 cycle after the offending di_en cycle.
REQ-028 di_en low SHALL leave the FSM and exp_idx unchanged; gaps mid-frame are legal.

Reset
REQ-029 On rst high at a clock edge, do_en, do_pow, out_group_idx, out_group_num, frame_done, and err_seq SHALL all become 0.
REQ-030 Reset SHALL set FSM to IDLE and exp_idx/cur_num to 0, and SHALL clear all pipeline valids.
REQ-031 Reset mid-frame SHALL discard in-flight samples, so no do_en appears for them after reset.

Structure
REQ-032 A shared package SHALL hold N_BIN, the FSM state typedef, and frame/index widths (10, 7).
REQ-033 One sub-module, ps_square_sum, SHALL implement the 2-stage square/sum/saturate datapath; the top SHALL hold the FSM and alignment registers.

Verification
REQ-034 Frame num 5, idx 0..512 contiguous, re=3 im=-4 -> 513 do_en with do_pow=25, first 3 cycles after first di_en, and frame_done only with idx 512.
REQ-035 re=im=-8192 with O_BW=28 -> do_pow=134217728; with O_BW=27 -> do_pow=134217727 (saturated).
REQ-036 Frame idx 0..511, then idx 0 again -> err_seq pulse, new frame accepted, and no frame_done for the first frame.
REQ-037 idx 600..1023 interleaved in a frame -> no do_en and no err_seq for them, and frame completes normally.
REQ-038 In IDLE, di_en with idx 7 -> err_seq one pulse, no do_en; and rst asserted at idx 200 -> all outputs 0, no do_en for samples in flight.
